// File: rtl/pq_sched_if.sv
// Scheduler-side bundle: queue status, weights and flow control in; grant and status out.
// The bench drives through the master modport and the scheduler uses the slave modport.
interface pq_sched_if #(
    parameter int num_of_priority = 8,
    parameter int priority_width  = 3,
    parameter int weight_width    = 4
);
    logic                                    sp0_wrr1;
    logic [num_of_priority*weight_width-1:0] wrr_weights;
    logic                                    weight_load;
    logic [num_of_priority-1:0]              q_nonempty;
    logic                                    out_ready;
    logic                                    rd_eop;
    logic [num_of_priority-1:0]              grant;
    logic [priority_width-1:0]               grant_id;
    logic                                    grant_vld;
    logic                                    busy;

    modport master (
        output sp0_wrr1, wrr_weights, weight_load, q_nonempty, out_ready, rd_eop,
        input  grant, grant_id, grant_vld, busy
    );

    modport slave (
        input  sp0_wrr1, wrr_weights, weight_load, q_nonempty, out_ready, rd_eop,
        output grant, grant_id, grant_vld, busy
    );
endinterface

// File: rtl/pq_scheduler.sv
// Per-output-port packet scheduler. It uses strict priority or packet-count WRR
// across the priority queues, and it holds each grant until the downstream signals end-of-packet.
module pq_scheduler #(
    parameter int num_of_priority = 8,
    parameter int priority_width  = 3,
    parameter int weight_width    = 4
) (
    input  logic       clk,
    input  logic       rst,
    pq_sched_if.slave  bus
);
    typedef enum logic {IDLE, XFER} state_t;

    state_t                    state_q, state_d;
    logic [num_of_priority-1:0] grant_q, grant_d;
    logic [priority_width-1:0]  grant_id_q, grant_id_d;
    logic                       vld_q, vld_d;
    logic                       mode_q, mode_d;
    logic                       load_pend_q, load_pend_d;
    logic [priority_width-1:0]  rr_ptr_q, rr_ptr_d;
    logic [weight_width-1:0]    credit_q [num_of_priority];
    logic [weight_width-1:0]    credit_d [num_of_priority];
    logic [weight_width-1:0]    reload_val [num_of_priority];
    logic [num_of_priority-1:0] eligible;

    genvar gi;
    generate
        for (gi = 0; gi < num_of_priority; gi++) begin : g_q
            logic [weight_width-1:0] w;
            assign w              = bus.wrr_weights[gi*weight_width +: weight_width];
            assign reload_val[gi] = (w == '0) ? {{(weight_width-1){1'b0}}, 1'b1} : w;
            assign eligible[gi]   = bus.q_nonempty[gi] && (credit_q[gi] != '0);
        end
    endgenerate

    logic [priority_width-1:0] sp_id, wrr_id, idx, sel;
    logic                      wrr_found, take;
    logic [weight_width-1:0]   dec;

    // Both scans run from the far end so that the nearest candidate is the last one written.
    // The rotating index wraps by truncation, so num_of_priority must be a power of two.
    always_comb begin
        sp_id     = '0;
        wrr_id    = '0;
        wrr_found = 1'b0;
        idx       = '0;
        for (int i = num_of_priority - 1; i >= 0; i--) begin
            if (bus.q_nonempty[i]) sp_id = i[priority_width-1:0];
        end
        for (int k = num_of_priority - 1; k >= 0; k--) begin
            idx = rr_ptr_q + k[priority_width-1:0];
            if (eligible[idx]) begin
                wrr_found = 1'b1;
                wrr_id    = idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        grant_id_d  = grant_id_q;
        vld_d       = vld_q;
        mode_d      = mode_q;
        load_pend_d = load_pend_q;
        rr_ptr_d    = rr_ptr_q;
        credit_d    = credit_q;
        sel         = '0;
        take        = 1'b0;
        dec         = '0;
        case (state_q)
            IDLE: begin
                if (load_pend_q || bus.weight_load) begin
                    credit_d    = reload_val;
                    load_pend_d = 1'b0;
                end else if (bus.out_ready && (bus.q_nonempty != '0)) begin
                    if (!bus.sp0_wrr1) begin
                        sel  = sp_id;
                        take = 1'b1;
                    end else if (wrr_found) begin
                        sel  = wrr_id;
                        take = 1'b1;
                    end else begin
                        credit_d = reload_val;
                    end
                end
                if (take) begin
                    grant_d      = '0;
                    grant_d[sel] = 1'b1;
                    grant_id_d   = sel;
                    vld_d        = 1'b1;
                    mode_d       = bus.sp0_wrr1;
                    state_d      = XFER;
                end
            end
            XFER: begin
                if (bus.weight_load) load_pend_d = 1'b1;
                if (bus.rd_eop) begin
                    grant_d = '0;
                    vld_d   = 1'b0;
                    state_d = IDLE;
                    if (mode_q) begin
                        dec = (credit_q[grant_id_q] != '0) ? credit_q[grant_id_q] - 1'b1 : '0;
                        credit_d[grant_id_q] = dec;
                        // A queue that still has credit keeps the pointer and continues its burst.
                        rr_ptr_d = (dec == '0) ? grant_id_q + 1'b1 : grant_id_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            grant_id_q  <= '0;
            vld_q       <= 1'b0;
            mode_q      <= 1'b0;
            load_pend_q <= 1'b0;
            rr_ptr_q    <= '0;
            for (int i = 0; i < num_of_priority; i++) credit_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            grant_id_q  <= grant_id_d;
            vld_q       <= vld_d;
            mode_q      <= mode_d;
            load_pend_q <= load_pend_d;
            rr_ptr_q    <= rr_ptr_d;
            credit_q    <= credit_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.grant_id  = grant_id_q;
    assign bus.grant_vld = vld_q;
    assign bus.busy      = (state_q == XFER);
endmodule

// File: tb/tb_pq_scheduler.sv
// Directed bench for pq_scheduler: expected grant ids are queued when stimulus is applied
// and compared as each grant appears.
module tb_pq_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   exp_q[$];

    pq_sched_if #(.num_of_priority(8), .priority_width(3), .weight_width(4)) bus ();

    pq_scheduler #(.num_of_priority(8), .priority_width(3), .weight_width(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Wait for the next grant, then check the wait time, id, one-hot grant and busy against the scoreboard.
    task automatic expect_grant(input string tag, input int exp_wait);
        int cnt = 0;
        int exp_id;
        logic [7:0] exp_grant;
        while (!bus.grant_vld && cnt < 20) begin
            tick();
            cnt++;
        end
        check({tag, "_vld"}, bus.grant_vld, 1'b1);
        if (exp_wait >= 0) check({tag, "_wait"}, cnt, exp_wait);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            exp_id = exp_q.pop_front();
            exp_grant = '0;
            exp_grant[exp_id] = 1'b1;
            check({tag, "_id"}, bus.grant_id, exp_id);
            check({tag, "_grant"}, bus.grant, exp_grant);
        end
        check({tag, "_busy"}, bus.busy, 1'b1);
        $display("txn %s: grant_id=%0d grant=%b wait=%0d", tag, bus.grant_id, bus.grant, cnt);
    endtask

    // Pulse rd_eop so that the n-th edge after the grant samples it, then confirm release.
    task automatic finish_pkt(input string tag, input int n);
        repeat (n - 1) tick();
        bus.rd_eop = 1'b1;
        tick();
        bus.rd_eop = 1'b0;
        check({tag, "_rel_vld"}, bus.grant_vld, 1'b0);
        check({tag, "_rel_grant"}, bus.grant, 8'h00);
        check({tag, "_rel_busy"}, bus.busy, 1'b0);
    endtask

    initial begin
        bus.sp0_wrr1    = 1'b0;
        bus.wrr_weights = '0;
        bus.weight_load = 1'b0;
        bus.q_nonempty  = '0;
        bus.out_ready   = 1'b0;
        bus.rd_eop      = 1'b0;

        // Reset state, then idle with no queues.
        tick();
        tick();
        check("rst_grant", bus.grant, 8'h00);
        check("rst_id", bus.grant_id, 3'd0);
        check("rst_vld", bus.grant_vld, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        rst = 1'b0;
        repeat (3) tick();
        check("idle_empty_vld", bus.grant_vld, 1'b0);

        // Strict priority.
        bus.out_ready  = 1'b1;
        bus.q_nonempty = 8'b1010_0100;
        for (int p = 0; p < 3; p++) begin
            exp_q.push_back(2);
            expect_grant("sp", 1);
            finish_pkt("sp", 4);
        end
        exp_q.push_back(2);
        exp_q.push_back(5);
        expect_grant("sp_clr", 1);
        bus.q_nonempty = 8'b1010_0000;
        tick();
        check("sp_clr_hold_id", bus.grant_id, 3'd2);
        check("sp_clr_hold_grant", bus.grant, 8'h04);
        finish_pkt("sp_clr", 3);
        expect_grant("sp_next", 1);

        // Asynchronous reset in the middle of a transfer.
        #3;
        rst = 1'b1;
        #1;
        check("arst_grant", bus.grant, 8'h00);
        check("arst_id", bus.grant_id, 3'd0);
        check("arst_vld", bus.grant_vld, 1'b0);
        check("arst_busy", bus.busy, 1'b0);
        @(posedge clk);
        #1;
        bus.q_nonempty = '0;
        rst = 1'b0;
        repeat (3) tick();
        check("arst_post_vld", bus.grant_vld, 1'b0);
        check("arst_post_grant", bus.grant, 8'h00);

        // Weighted round robin with weights q0=2, q1=1, q2=3.
        bus.sp0_wrr1    = 1'b1;
        bus.wrr_weights = 32'h1111_1312;
        do_reset();
        bus.q_nonempty = 8'b0000_0111;
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back(0);
            exp_q.push_back(0);
            exp_q.push_back(1);
            exp_q.push_back(2);
            exp_q.push_back(2);
            exp_q.push_back(2);
        end
        tick();
        check("wrr_first_reload_vld", bus.grant_vld, 1'b0);
        for (int p = 0; p < 12; p++) begin
            expect_grant("wrr", (p == 6) ? 2 : 1);
            finish_pkt("wrr", 3);
        end

        // A zero weight behaves as a weight of one.
        bus.wrr_weights = 32'h1111_0111;
        do_reset();
        bus.q_nonempty = 8'b0000_1000;
        for (int p = 0; p < 3; p++) begin
            exp_q.push_back(3);
            expect_grant("w0", 2);
            finish_pkt("w0", 2);
        end

        // Flow control, and events deferred while a packet is in flight.
        bus.sp0_wrr1    = 1'b0;
        bus.wrr_weights = 32'h1111_1111;
        bus.out_ready   = 1'b0;
        do_reset();
        bus.q_nonempty = 8'b0000_0110;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("nordy_vld", bus.grant_vld, 1'b0);
        end
        bus.out_ready = 1'b1;
        exp_q.push_back(1);
        expect_grant("defer", 1);
        bus.sp0_wrr1    = 1'b1;
        bus.weight_load = 1'b1;
        bus.q_nonempty  = 8'b0000_1000;
        bus.out_ready   = 1'b0;
        tick();
        bus.weight_load = 1'b0;
        check("defer_hold_id", bus.grant_id, 3'd1);
        check("defer_hold_vld", bus.grant_vld, 1'b1);
        tick();
        check("defer_hold_grant", bus.grant, 8'h02);
        bus.out_ready  = 1'b1;
        bus.q_nonempty = 8'b0000_0110;
        finish_pkt("defer", 2);
        exp_q.push_back(1);
        exp_q.push_back(2);
        expect_grant("defer_wrr", 2);
        finish_pkt("defer_wrr", 2);
        expect_grant("defer_wrr", 1);
        finish_pkt("defer_wrr", 2);

        // Minimum gap between back-to-back packets.
        bus.sp0_wrr1 = 1'b0;
        do_reset();
        bus.q_nonempty = 8'b0000_0001;
        for (int p = 0; p < 4; p++) begin
            exp_q.push_back(0);
            expect_grant("gap", 1);
            tick();
            check("gap_second_hi", bus.grant_vld, 1'b1);
            bus.rd_eop = 1'b1;
            tick();
            bus.rd_eop = 1'b0;
            check("gap_low", bus.grant_vld, 1'b0);
        end

        check("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
